// File: rtl/ddr3_app_adapter.sv
// ddr3_app_adapter: line-granular request/response front end for the DDR3
// controller native app interface. One request is held at a time; its command
// (app_en) and write data (app_wdf_wren) are handed off independently, and read
// commands only issue while the response FIFO has room for every read in flight.
//
// Handshakes: every valid/ready style pair transfers on the rising CLK edge
// where both sides are high (req_valid&req_ready, rsp_valid&rsp_ready,
// app_en&app_rdy, app_wdf_wren&app_wdf_rdy). A producer holds its payload
// stable while its strobe is high and not yet accepted; app_rd_data_valid has
// no back-pressure and is always taken.
module ddr3_app_adapter #(
  parameter int LINE_ADDR_WIDTH = 25,
  parameter int ADDR_SHIFT      = 3,
  parameter int APP_ADDR_WIDTH  = 28,
  parameter int DATA_WIDTH      = 512,
  parameter int RSP_DEPTH       = 8
) (
  input  logic                           CLK,
  input  logic                           RST_N,
  input  logic                           init_calib_complete,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_write,
  input  logic [LINE_ADDR_WIDTH-1:0]     req_addr,
  input  logic [DATA_WIDTH-1:0]          req_data,
  input  logic [DATA_WIDTH/8-1:0]        req_byteen,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [DATA_WIDTH-1:0]          rsp_data,
  output logic [APP_ADDR_WIDTH-1:0]      app_addr,
  output logic [2:0]                     app_cmd,
  output logic                           app_en,
  input  logic                           app_rdy,
  output logic [DATA_WIDTH-1:0]          app_wdf_data,
  output logic [DATA_WIDTH/8-1:0]        app_wdf_mask,
  output logic                           app_wdf_wren,
  output logic                           app_wdf_end,
  input  logic                           app_wdf_rdy,
  input  logic [DATA_WIDTH-1:0]          app_rd_data,
  input  logic                           app_rd_data_valid,
  output logic [$clog2(RSP_DEPTH):0]     rd_inflight,
  output logic                           err_overflow,
  output logic                           dbg_state
);

  localparam int MW = DATA_WIDTH / 8;
  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] CNT_ONE  = 1;
  localparam logic [PW-1:0] PTR_ONE  = 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(RSP_DEPTH);
  localparam logic [CW:0]   DEPTH_W  = (CW+1)'(RSP_DEPTH);

  typedef enum logic {S_IDLE = 1'b0, S_ISSUE = 1'b1} state_t;

  state_t                     state_q, state_d;
  logic                       write_q, write_d;
  logic [LINE_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]      data_q, data_d;
  logic [MW-1:0]              byteen_q, byteen_d;
  logic                       cmd_done_q, cmd_done_d;
  logic                       data_done_q, data_done_d;
  logic [CW-1:0]              inflight_q, inflight_d;
  logic [CW-1:0]              count_q, count_d;
  logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
  logic                       err_q, err_d;
  logic [DATA_WIDTH-1:0]      mem_q [RSP_DEPTH];

  logic [CW:0] credit_sum;
  logic        has_credit;
  logic        rd_cmd_acc;
  logic        fifo_full;
  logic        push;
  logic        pop;
  logic        overflow;

  // Reads already issued plus beats already buffered must leave a free slot.
  assign credit_sum = {1'b0, inflight_q} + {1'b0, count_q};
  assign has_credit = credit_sum < DEPTH_W;

  // Request FSM: accept in IDLE, hand off command and data in ISSUE.
  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    addr_d      = addr_q;
    data_d      = data_q;
    byteen_d    = byteen_q;
    cmd_done_d  = cmd_done_q;
    data_done_d = data_done_q;
    req_ready   = 1'b0;
    app_en      = 1'b0;
    app_wdf_wren = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = init_calib_complete & RST_N;
        if (req_valid && req_ready) begin
          write_d     = req_write;
          addr_d      = req_addr;
          data_d      = req_data;
          byteen_d    = req_byteen;
          cmd_done_d  = 1'b0;
          // A read has no data phase, so it starts out data-complete.
          data_done_d = !req_write;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        app_en       = !cmd_done_q && (write_q || has_credit);
        app_wdf_wren = write_q && !data_done_q;
        if (app_en && app_rdy)             cmd_done_d  = 1'b1;
        if (app_wdf_wren && app_wdf_rdy)   data_done_d = 1'b1;
        if (cmd_done_q && data_done_q)     state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rd_cmd_acc = app_en && app_rdy && !write_q;

  // Outstanding read counter; underflow is held off for unsolicited beats.
  always_comb begin
    inflight_d = inflight_q;
    case ({rd_cmd_acc, app_rd_data_valid})
      2'b10:   inflight_d = inflight_q + CNT_ONE;
      2'b01:   if (inflight_q != '0) inflight_d = inflight_q - CNT_ONE;
      default: inflight_d = inflight_q;
    endcase
  end

  assign fifo_full = (count_q == DEPTH_C);
  assign pop       = rsp_valid && rsp_ready;
  assign push      = app_rd_data_valid && (!fifo_full || pop);
  assign overflow  = app_rd_data_valid && fifo_full && !pop;

  // Response FIFO pointers, occupancy and sticky overflow flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q | overflow;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Control state with asynchronous reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      cmd_done_q  <= 1'b0;
      data_done_q <= 1'b0;
      inflight_q  <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_done_q  <= cmd_done_d;
      data_done_q <= data_done_d;
      inflight_q  <= inflight_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      err_q       <= err_d;
    end
  end

  // Held request payload; contents only matter while in ISSUE.
  always_ff @(posedge CLK) begin
    write_q  <= write_d;
    addr_q   <= addr_d;
    data_q   <= data_d;
    byteen_q <= byteen_d;
  end

  // FIFO storage; a pushed beat becomes visible on the next cycle.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= app_rd_data;
  end

  assign rsp_valid    = (count_q != '0);
  assign rsp_data     = mem_q[rd_ptr_q];
  assign app_addr     = {addr_q, {ADDR_SHIFT{1'b0}}};
  assign app_cmd      = write_q ? 3'b000 : 3'b001;
  assign app_wdf_data = data_q;
  assign app_wdf_mask = ~byteen_q;
  assign app_wdf_end  = app_wdf_wren;
  assign rd_inflight  = inflight_q;
  assign err_overflow = err_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_ddr3_app_adapter.sv
// tb_ddr3_app_adapter: directed bench for ddr3_app_adapter. Inputs change on
// the falling edge, outputs are checked 1 ns later. Read data comes from a
// per-address pattern function; expected responses are queued when each read
// request is driven and compared in order as the DUT hands them out.
module tb_ddr3_app_adapter;

  localparam int LAW = 25;
  localparam int SH  = 3;
  localparam int AAW = 28;
  localparam int DW  = 512;
  localparam int MW  = 64;
  localparam int DEP = 8;
  localparam int CW  = 4;

  // Clock and reset
  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  logic           init_calib_complete = 1'b0;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic           req_write = 1'b0;
  logic [LAW-1:0] req_addr = '0;
  logic [DW-1:0]  req_data = '0;
  logic [MW-1:0]  req_byteen = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [DW-1:0]  rsp_data;
  logic [AAW-1:0] app_addr;
  logic [2:0]     app_cmd;
  logic           app_en;
  logic           app_rdy = 1'b0;
  logic [DW-1:0]  app_wdf_data;
  logic [MW-1:0]  app_wdf_mask;
  logic           app_wdf_wren;
  logic           app_wdf_end;
  logic           app_wdf_rdy = 1'b0;
  logic [DW-1:0]  app_rd_data = '0;
  logic           app_rd_data_valid = 1'b0;
  logic [CW-1:0]  rd_inflight;
  logic           err_overflow;
  logic           dbg_state;

  ddr3_app_adapter #(
    .LINE_ADDR_WIDTH(LAW), .ADDR_SHIFT(SH), .APP_ADDR_WIDTH(AAW),
    .DATA_WIDTH(DW), .RSP_DEPTH(DEP)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .init_calib_complete(init_calib_complete),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_data(req_data), .req_byteen(req_byteen),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data),
    .app_rd_data_valid(app_rd_data_valid), .rd_inflight(rd_inflight),
    .err_overflow(err_overflow), .dbg_state(dbg_state)
  );

  // Scoreboard state
  int             n_checks = 0;
  int             n_pass   = 0;
  logic [DW-1:0]  exp_q[$];
  logic [AAW-1:0] issued_q[$];

  function automatic logic [DW-1:0] model_data(input logic [AAW-1:0] a);
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++)
      d[i*32 +: 32] = (32'(a) * 32'h9E37_79B1) ^ (32'h0101_0101 * 32'(i));
    return d;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Records read commands the controller accepts, sampled mid-cycle.
  always @(negedge CLK) begin
    #3;
    if (RST_N && app_en && app_rdy && app_cmd == 3'b001) issued_q.push_back(app_addr);
  end

  // Driver tasks
  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic send(input logic w, input logic [LAW-1:0] a,
                      input logic [DW-1:0] d, input logic [MW-1:0] be);
    req_valid = 1'b1; req_write = w; req_addr = a; req_data = d; req_byteen = be;
    #1 chk("req_ready_idle", DW'(req_ready), DW'(1));
    tick();
    req_valid = 1'b0;
  endtask

  // Read with credit and app_rdy=1: one strobe cycle, one completion cycle.
  task automatic do_read(input logic [LAW-1:0] a);
    exp_q.push_back(model_data({a, 3'b000}));
    send(1'b0, a, '0, '0);
    #1;
    chk("rd_app_en", DW'(app_en), DW'(1));
    chk("rd_app_cmd", DW'(app_cmd), DW'(3'b001));
    chk("rd_app_addr", DW'(app_addr), DW'({a, 3'b000}));
    tick();
    #1 chk("rd_app_en_done", DW'(app_en), DW'(0));
    tick();
  endtask

  task automatic ret_one();
    logic [AAW-1:0] a;
    chk("issued_pending", DW'(issued_q.size() != 0), DW'(1));
    a = (issued_q.size() != 0) ? issued_q.pop_front() : '0;
    app_rd_data = model_data(a);
    app_rd_data_valid = 1'b1;
    tick();
    app_rd_data_valid = 1'b0;
  endtask

  // Return outstanding reads and pop responses until the scoreboard is empty.
  task automatic drain(input bit random_ret);
    logic [AAW-1:0] a;
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 300) begin
      app_rd_data_valid = 1'b0;
      if (issued_q.size() != 0 && (!random_ret || $urandom_range(0, 1) == 1)) begin
        a = issued_q.pop_front();
        app_rd_data = model_data(a);
        app_rd_data_valid = 1'b1;
      end
      rsp_ready = 1'($urandom_range(0, 1));
      #1;
      if (rsp_valid && rsp_ready) chk("rsp_data_order", rsp_data, exp_q.pop_front());
      tick();
      cyc++;
    end
    app_rd_data_valid = 1'b0;
    rsp_ready = 1'b0;
    chk("drain_in_budget", DW'(cyc < 300), DW'(1));
    #1 chk("rsp_valid_drained", DW'(rsp_valid), DW'(0));
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    logic [LAW-1:0] ra;

    // Reset state
    repeat (3) tick();
    #1;
    chk("rst_req_ready", DW'(req_ready), DW'(0));
    chk("rst_app_en", DW'(app_en), DW'(0));
    chk("rst_wren", DW'(app_wdf_wren), DW'(0));
    chk("rst_rsp_valid", DW'(rsp_valid), DW'(0));
    chk("rst_inflight", DW'(rd_inflight), DW'(0));
    chk("rst_err", DW'(err_overflow), DW'(0));
    tick();
    RST_N = 1'b1;
    tick();

    // Calibration gate
    d1 = model_data(28'h123_4567) ^ {DW{1'b1}};
    req_valid = 1'b1; req_write = 1'b1; req_addr = 25'h10; req_data = d1; req_byteen = '1;
    app_rdy = 1'b0; app_wdf_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("calib_req_ready", DW'(req_ready), DW'(0));
      chk("calib_app_en", DW'(app_en), DW'(0));
      tick();
    end
    init_calib_complete = 1'b1;

    // Write, data before command
    send(1'b1, 25'h10, d1, '1);
    #1;
    chk("wd_wren", DW'(app_wdf_wren), DW'(1));
    chk("wd_end", DW'(app_wdf_end), DW'(1));
    chk("wd_mask", DW'(app_wdf_mask), DW'(0));
    chk("wd_data", app_wdf_data, d1);
    chk("wd_app_en", DW'(app_en), DW'(1));
    chk("wd_addr", DW'(app_addr), DW'(28'h80));
    chk("wd_cmd", DW'(app_cmd), DW'(3'b000));
    chk("wd_busy", DW'(req_ready), DW'(0));
    tick();
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("wd_wren_once", DW'(app_wdf_wren), DW'(0));
      chk("wd_en_held", DW'(app_en), DW'(1));
      chk("wd_addr_held", DW'(app_addr), DW'(28'h80));
      chk("wd_cmd_held", DW'(app_cmd), DW'(3'b000));
      tick();
    end
    app_rdy = 1'b1;
    #1 chk("wd_en_accept", DW'(app_en), DW'(1));
    tick();
    #1;
    chk("wd_en_off", DW'(app_en), DW'(0));
    chk("wd_not_idle", DW'(req_ready), DW'(0));
    tick();
    #1;
    chk("wd_idle_ready", DW'(req_ready), DW'(1));
    chk("wd_idle_state", DW'(dbg_state), DW'(0));
    tick();

    // Write, command before data
    d2 = model_data(28'h0ABC_DEF0);
    app_rdy = 1'b1; app_wdf_rdy = 1'b0;
    send(1'b1, 25'h20, d2, 64'h0FFF_FFFF_FFFF_FFF0);
    #1;
    chk("wc_app_en", DW'(app_en), DW'(1));
    chk("wc_wren", DW'(app_wdf_wren), DW'(1));
    chk("wc_mask", DW'(app_wdf_mask), DW'(64'hF000_0000_0000_000F));
    chk("wc_addr", DW'(app_addr), DW'(28'h100));
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("wc_en_once", DW'(app_en), DW'(0));
      chk("wc_wren_held", DW'(app_wdf_wren), DW'(1));
      chk("wc_end_held", DW'(app_wdf_end), DW'(1));
      tick();
    end
    app_wdf_rdy = 1'b1;
    #1;
    chk("wc_wren_accept", DW'(app_wdf_wren), DW'(1));
    chk("wc_data", app_wdf_data, d2);
    tick();
    #1;
    chk("wc_wren_off", DW'(app_wdf_wren), DW'(0));
    chk("wc_issue_state", DW'(dbg_state), DW'(1));
    tick();
    #1 chk("wc_idle_ready", DW'(req_ready), DW'(1));
    tick();

    // Read credit limit
    rsp_ready = 1'b0;
    for (int i = 0; i < DEP; i++) begin
      ra = LAW'($urandom_range(0, 32'h00FF_FFFF));
      do_read(ra);
    end
    #1 chk("cr_inflight_full", DW'(rd_inflight), DW'(DEP));
    tick();
    ra = LAW'($urandom_range(0, 32'h00FF_FFFF));
    exp_q.push_back(model_data({ra, 3'b000}));
    send(1'b0, ra, '0, '0);
    for (int i = 0; i < 2; i++) begin
      #1 chk("cr_blocked", DW'(app_en), DW'(0));
      tick();
    end
    ret_one();
    rsp_ready = 1'b1;
    #1;
    chk("cr_rsp_valid", DW'(rsp_valid), DW'(1));
    chk("cr_still_blocked", DW'(app_en), DW'(0));
    chk("cr_inflight_dec", DW'(rd_inflight), DW'(DEP - 1));
    chk("cr_first_data", rsp_data, exp_q.pop_front());
    tick();
    rsp_ready = 1'b0;
    #1 chk("cr_unblocked", DW'(app_en), DW'(1));
    tick();
    drain(1'b1);
    #1 chk("cr_inflight_zero", DW'(rd_inflight), DW'(0));
    tick();

    // Ordering under back-pressure: three reads, spaced returns
    for (int i = 0; i < 3; i++) begin
      ra = LAW'($urandom_range(0, 32'h01FF_FFFF));
      do_read(ra);
    end
    drain(1'b1);
    #1 chk("ord_no_err", DW'(err_overflow), DW'(0));
    tick();

    // FIFO full, then an unsolicited beat is dropped
    for (int i = 0; i < DEP; i++) begin
      ra = LAW'($urandom_range(0, 32'h01FF_FFFF));
      do_read(ra);
    end
    for (int i = 0; i < DEP; i++) ret_one();
    #1;
    chk("ov_inflight", DW'(rd_inflight), DW'(0));
    chk("ov_no_err_yet", DW'(err_overflow), DW'(0));
    app_rd_data = {DW{1'b1}};
    app_rd_data_valid = 1'b1;
    tick();
    app_rd_data_valid = 1'b0;
    #1;
    chk("ov_err_set", DW'(err_overflow), DW'(1));
    chk("ov_inflight_hold", DW'(rd_inflight), DW'(0));
    tick();
    drain(1'b0);
    #1 chk("ov_err_sticky", DW'(err_overflow), DW'(1));
    tick();

    // Reset in the middle of an ISSUE
    do_read(25'h0_0777);
    ret_one();
    do_read(25'h0_0888);
    app_rdy = 1'b0;
    send(1'b0, 25'h0_0999, '0, '0);
    #1;
    chk("rm_en_before", DW'(app_en), DW'(1));
    chk("rm_rsp_before", DW'(rsp_valid), DW'(1));
    chk("rm_inflight_before", DW'(rd_inflight), DW'(1));
    #1 RST_N = 1'b0;
    #1;
    chk("rm_en_cleared", DW'(app_en), DW'(0));
    chk("rm_rsp_cleared", DW'(rsp_valid), DW'(0));
    chk("rm_inflight_cleared", DW'(rd_inflight), DW'(0));
    chk("rm_err_cleared", DW'(err_overflow), DW'(0));
    chk("rm_ready_cleared", DW'(req_ready), DW'(0));
    tick();
    exp_q.delete();
    issued_q.delete();
    tick();
    RST_N = 1'b1;
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;

    // First request after reset: command and data in the same cycle
    send(1'b1, 25'h1_2345, d2, '1);
    #1;
    chk("pr_app_en", DW'(app_en), DW'(1));
    chk("pr_wren", DW'(app_wdf_wren), DW'(1));
    chk("pr_addr", DW'(app_addr), DW'(28'h91A28));
    tick();
    #1;
    chk("pr_both_done", DW'(app_en | app_wdf_wren), DW'(0));
    chk("pr_not_idle", DW'(req_ready), DW'(0));
    tick();
    #1 chk("pr_idle", DW'(req_ready), DW'(1));
    tick();
    do_read(25'h1_5555);
    drain(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
